// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains fifo_async through its fixed read latency and re-presents
// the words as a full-throughput valid/ready stream with flush and a transfer counter.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  localparam int unsigned BUF_DEPTH = RD_LATENCY + 2;
  localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W     = OCC_W + 1;
  localparam int unsigned IFL_W     = $clog2(RD_LATENCY + 1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [RD_LATENCY-1:0] pend_q, pend_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IFL_W-1:0]      inflight;
  logic                  cap;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads already issued but not yet captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + IFL_W'(pend_q[i]);
    end
  end

  // Issue only when every issued read is guaranteed a buffer slot; m_ready is not involved.
  assign rd_en = rd_rst_n & ~empty & ~flush &
                 ((SUM_W'(occ_q) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH));

  assign cap        = pend_q[RD_LATENCY-1];
  assign m_valid    = (occ_q != '0);
  assign m_data     = mem_q[head_q];
  assign pop        = m_valid & m_ready;
  assign xfer_count = cnt_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    pend_d = RD_LATENCY'({pend_q, rd_en});

    if (cap) tail_d = ptr_inc(tail_q);
    if (pop) head_d = ptr_inc(head_q);

    case ({cap, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (pop && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);

    // Flush drops buffered and in-flight words but keeps the counter.
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      pend_d = '0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (cap && !flush) mem_q[tail_q] <= rd_data;
    end
  end

  // Every read was issued with occ+inflight < BUF_DEPTH, so a capture always finds a free slot.
  a_no_capture_when_full: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(cap && (occ_q == OCC_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: instance a uses RD_LATENCY=1, CNT_WIDTH=16;
// instance b uses RD_LATENCY=2, CNT_WIDTH=4. A queue-based FIFO model feeds both.
module tb_fifo_rd_stream;

  logic        clk;
  logic        rst_n_a, empty_a, rd_en_a, m_valid_a, m_ready_a, flush_a;
  logic [7:0]  rd_data_a, m_data_a;
  logic [15:0] xfer_a;
  logic        rst_n_b, empty_b, rd_en_b, m_valid_b, m_ready_b, flush_b;
  logic [7:0]  rd_data_b, m_data_b;
  logic [3:0]  xfer_b;

  int checks;
  int errors;

  logic [7:0] fq_a[$];
  logic [7:0] fq_b[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] pa, pb0, pb1;
  int issued_a, issued_b, done_a, done_b;

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1), .CNT_WIDTH(16)) dut_a (
    .rd_clk(clk), .rd_rst_n(rst_n_a), .empty(empty_a), .rd_data(rd_data_a),
    .rd_en(rd_en_a), .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready_a),
    .flush(flush_a), .xfer_count(xfer_a)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2), .CNT_WIDTH(4)) dut_b (
    .rd_clk(clk), .rd_rst_n(rst_n_b), .empty(empty_b), .rd_data(rd_data_b),
    .rd_en(rd_en_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready_b),
    .flush(flush_b), .xfer_count(xfer_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_a(input logic [7:0] w);
    fq_a.push_back(w);
    exp_a.push_back(w);
  endtask

  task automatic push_b(input logic [7:0] w);
    fq_b.push_back(w);
    exp_b.push_back(w);
  endtask

  // One cycle from a negedge: FIFO model, read-data pipes, scoreboard, then next negedge.
  task automatic step();
    logic [7:0] w;
    logic [7:0] e;
    #1;
    empty_a   = (fq_a.size() == 0);
    empty_b   = (fq_b.size() == 0);
    rd_data_a = pa;
    rd_data_b = pb1;
    pb1       = pb0;
    #1;
    checks++;
    if (issued_a - done_a > 3) begin
      errors++;
      $display("FAIL occ_bound_a got %0d outstanding want <= 3", issued_a - done_a);
    end
    checks++;
    if (issued_b - done_b > 4) begin
      errors++;
      $display("FAIL occ_bound_b got %0d outstanding want <= 4", issued_b - done_b);
    end
    w = 8'($urandom);
    if (rd_en_a) begin
      checks++;
      if (empty_a || fq_a.size() == 0) begin
        errors++;
        $display("FAIL rd_en_a_empty got rd_en=1 with empty=1 want rd_en=0");
      end else begin
        w = fq_a.pop_front();
      end
      issued_a++;
    end
    pa = w;
    w = 8'($urandom);
    if (rd_en_b) begin
      checks++;
      if (empty_b || fq_b.size() == 0) begin
        errors++;
        $display("FAIL rd_en_b_empty got rd_en=1 with empty=1 want rd_en=0");
      end else begin
        w = fq_b.pop_front();
      end
      issued_b++;
    end
    pb0 = w;
    if (m_valid_a && m_ready_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL order_a got %02h want no word", m_data_a);
      end else begin
        e = exp_a.pop_front();
        if (m_data_a !== e) begin
          errors++;
          $display("FAIL order_a got %02h want %02h", m_data_a, e);
        end
      end
      done_a++;
    end
    if (m_valid_b && m_ready_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL order_b got %02h want no word", m_data_b);
      end else begin
        e = exp_b.pop_front();
        if (m_data_b !== e) begin
          errors++;
          $display("FAIL order_b got %02h want %02h", m_data_b, e);
        end
      end
      done_b++;
    end
    @(negedge clk);
  endtask

  task automatic wait_drain_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (fq_a.size() == 0 && exp_a.size() == 0 && !m_valid_a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_drain_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (fq_b.size() == 0 && exp_b.size() == 0 && !m_valid_b) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    fq_b.push_back(8'hAA);
    step();
    step();
    checks++;
    if (m_valid_a !== 1'b0 || m_data_a !== 8'h00 || xfer_a !== 16'h0000 || rd_en_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got v=%0b d=%02h cnt=%0d rd_en=%0b want 0 00 0 0",
               m_valid_a, m_data_a, xfer_a, rd_en_a);
    end
    checks++;
    if (m_valid_b !== 1'b0 || m_data_b !== 8'h00 || xfer_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_b got v=%0b d=%02h cnt=%0d want 0 00 0", m_valid_b, m_data_b, xfer_b);
    end
    checks++;
    if (rd_en_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en_gate got rd_en=%0b with empty=%0b want 0", rd_en_b, empty_b);
    end
    void'(fq_b.pop_back());
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    step();
  endtask

  task automatic test_stream();
    int first_rd, first_v, last_v, nv, nrd, i0;
    bit ok;
    first_rd = -1; first_v = -1; last_v = -1; nv = 0;
    nrd = issued_a;
    for (int i = 0; i < 5; i++) push_a(8'(8'h11 + i));
    m_ready_a = 1'b1;
    for (int c = 0; c < 14; c++) begin
      i0 = issued_a;
      step();
      if (issued_a != i0 && first_rd < 0) first_rd = c;
      if (m_valid_a) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
    end
    nrd = issued_a - nrd;
    checks++;
    if (nrd != 5) begin
      errors++;
      $display("FAIL stream_rd_cycles got %0d want 5", nrd);
    end
    checks++;
    if (first_v - first_rd + 1 != 2) begin
      errors++;
      $display("FAIL stream_first_valid got %0d edges want 2", first_v - first_rd + 1);
    end
    checks++;
    if (nv != 5 || last_v - first_v + 1 != 5) begin
      errors++;
      $display("FAIL stream_contiguous got %0d valid over %0d cycles want 5 over 5",
               nv, last_v - first_v + 1);
    end
    wait_drain_a(ok);
    checks++;
    if (!ok || xfer_a !== 16'd5) begin
      errors++;
      $display("FAIL stream_count got cnt=%0d drained=%0b want 5 1", xfer_a, ok);
    end
  endtask

  task automatic test_backpressure();
    int nrd;
    bit ok;
    m_ready_a = 1'b0;
    nrd = issued_a;
    for (int i = 0; i < 8; i++) push_a(8'(8'h11 + i));
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_valid_a) begin
        checks++;
        if (m_data_a !== 8'h11) begin
          errors++;
          $display("FAIL bp_hold got %02h want 11", m_data_a);
        end
      end
    end
    checks++;
    if (issued_a - nrd != 3) begin
      errors++;
      $display("FAIL bp_rd_stop got %0d reads want 3", issued_a - nrd);
    end
    m_ready_a = 1'b1;
    wait_drain_a(ok);
    checks++;
    if (!ok || xfer_a !== 16'd13) begin
      errors++;
      $display("FAIL bp_drain got cnt=%0d drained=%0b want 13 1", xfer_a, ok);
    end
  endtask

  task automatic test_flush();
    int i0;
    bit ok;
    m_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h21 + i));
    step();
    step();
    step();
    checks++;
    if (m_valid_a !== 1'b1 || m_data_a !== 8'h21) begin
      errors++;
      $display("FAIL flush_pre got v=%0b d=%02h want 1 21", m_valid_a, m_data_a);
    end
    flush_a = 1'b1;
    i0 = issued_a;
    step();
    flush_a = 1'b0;
    checks++;
    if (issued_a != i0) begin
      errors++;
      $display("FAIL flush_rd_en got %0d reads want 0", issued_a - i0);
    end
    checks++;
    if (m_valid_a !== 1'b0 || xfer_a !== 16'd13) begin
      errors++;
      $display("FAIL flush_clear got v=%0b cnt=%0d want 0 13", m_valid_a, xfer_a);
    end
    // Two buffered words and one in flight are discarded.
    for (int i = 0; i < 3; i++) void'(exp_a.pop_front());
    issued_a = done_a;
    m_ready_a = 1'b1;
    wait_drain_a(ok);
    checks++;
    if (!ok || xfer_a !== 16'd14) begin
      errors++;
      $display("FAIL flush_next got cnt=%0d drained=%0b want 14 1", xfer_a, ok);
    end
    m_ready_a = 1'b0;
    push_a(8'h5A);
    for (int i = 0; i < 10; i++) begin
      if (m_valid_a) break;
      step();
    end
    checks++;
    if (m_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL flush_xfer_wait got v=%0b want 1", m_valid_a);
    end
    flush_a = 1'b1;
    m_ready_a = 1'b1;
    step();
    flush_a = 1'b0;
    m_ready_a = 1'b0;
    issued_a = done_a;
    checks++;
    if (xfer_a !== 16'd15 || m_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_coincident got cnt=%0d v=%0b want 15 0", xfer_a, m_valid_a);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    m_ready_b = 1'b1;
    for (int i = 0; i < 10; i++) push_b(8'($urandom));
    wait_drain_b(ok);
    checks++;
    if (!ok || xfer_b !== 4'd10) begin
      errors++;
      $display("FAIL sat_mid got cnt=%0d drained=%0b want 10 1", xfer_b, ok);
    end
    for (int i = 0; i < 10; i++) push_b(8'($urandom));
    wait_drain_b(ok);
    checks++;
    if (!ok || xfer_b !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold got cnt=%0d drained=%0b want 15 1", xfer_b, ok);
    end
  endtask

  task automatic test_random();
    int pushed, d0, n;
    bit ok;
    pushed = 0;
    d0 = done_b;
    for (int c = 0; c < 300; c++) begin
      m_ready_b = 1'($urandom_range(0, 1));
      if (pushed < 60 && $urandom_range(0, 3) == 0) begin
        n = int'($urandom_range(1, 4));
        for (int k = 0; k < n && pushed < 60; k++) begin
          push_b(8'($urandom));
          pushed++;
        end
      end
      step();
    end
    m_ready_b = 1'b1;
    wait_drain_b(ok);
    checks++;
    if (!ok || done_b - d0 != pushed) begin
      errors++;
      $display("FAIL random_all got %0d words drained=%0b want %0d 1", done_b - d0, ok, pushed);
    end
    checks++;
    if (xfer_b !== 4'd15) begin
      errors++;
      $display("FAIL random_cnt got %0d want 15", xfer_b);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    m_ready_b = 1'b0;
    push_b(8'h31);
    push_b(8'h32);
    push_b(8'h33);
    step();
    step();
    rst_n_b = 1'b0;
    step();
    rst_n_b = 1'b1;
    checks++;
    if (m_valid_b !== 1'b0 || xfer_b !== 4'd0) begin
      errors++;
      $display("FAIL midrst_clear got v=%0b cnt=%0d want 0 0", m_valid_b, xfer_b);
    end
    // Both in-flight words are lost to the reset.
    void'(exp_b.pop_front());
    void'(exp_b.pop_front());
    issued_b = done_b;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (m_valid_b !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stray got v=%0b d=%02h want 0", m_valid_b, m_data_b);
      end
    end
    m_ready_b = 1'b1;
    wait_drain_b(ok);
    checks++;
    if (!ok || xfer_b !== 4'd1) begin
      errors++;
      $display("FAIL midrst_after got cnt=%0d drained=%0b want 1 1", xfer_b, ok);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    issued_a = 0; issued_b = 0; done_a = 0; done_b = 0;
    pa = 8'h00; pb0 = 8'h00; pb1 = 8'h00;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    empty_a = 1'b1; empty_b = 1'b1;
    rd_data_a = 8'h00; rd_data_b = 8'h00;
    m_ready_a = 1'b0; m_ready_b = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of fifo_async. Runs in the rd_clk domain.
- Drives rd_en from empty and captures rd_data after a fixed read latency.
- Re-presents the captured words as a valid/ready stream with full throughput and no combinational path from m_ready to rd_en.
- Provides a flush and a saturating transfer counter for the downstream pipeline.

Parameters:
- DATA_WIDTH, 8: word width; must equal the fifo_async DATA_WIDTH.
- RD_LATENCY, 1: cycles from rd_en high to rd_data valid. Legal values are 1 and 2.
- CNT_WIDTH, 16: width of xfer_count.
- Internal constant BUF_DEPTH = RD_LATENCY+2 is the skid buffer entry count.

Ports:
- rd_clk  in  1  single clock for all logic.
- rd_rst_n  in  1  reset; synchronous, active-low.
- empty  in  1  FIFO empty flag.
- rd_data  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after rd_en.
- rd_en  out  1  FIFO read strobe.
- m_valid  out  1  output word valid.
- m_data  out  DATA_WIDTH  output word.
- m_ready  in  1  downstream accept.
- flush  in  1  discard buffered and in-flight words.
- xfer_count  out  CNT_WIDTH  accepted-word count; saturates at all-ones.

Behaviour:
- Reset: while rd_rst_n=0 at a rd_clk edge, all state clears. Buffer occupancy, in-flight pipe and counter go to 0. After that edge, m_valid=0, m_data=0 and xfer_count=0; rd_en=0 because it is gated by rd_rst_n.
- Reset mid-operation: in-flight words returning after reset are dropped, because their pending bits are cleared.
- In-flight tracking: pend[RD_LATENCY-1:0] is a shift register of read-issue flags; pend[0] is set by rd_en. inflight is the popcount of pend.
- rd_en (combinational, from registered state only): rd_en = rd_rst_n & !empty & !flush & (occ + inflight < BUF_DEPTH).
  - rd_en is never asserted while empty=1.
  - rd_en does not depend on m_ready.
- Capture: when pend[RD_LATENCY-1]=1, rd_data is written to the buffer tail at that edge.
- Pop: a transfer is m_valid & m_ready. The head advances at that edge.
- Output: m_valid = (occ != 0). m_data = buffer head. m_data is held stable while m_valid=1 and m_ready=0.
- Simultaneous capture and pop: occupancy stays unchanged and order is preserved. Capturing into a full buffer is impossible by construction; add a formal assertion for it.
- Buffer pointers wrap modulo BUF_DEPTH.
- Throughput: with empty=0 and m_ready=1, 1 word per cycle is sustained. The first m_valid rises RD_LATENCY+1 edges after the first rd_en edge.
- flush (registered effect at the edge):
  - occ, pointers and pend clear.
  - rd_en=0 in the flush cycle.
  - m_valid=0 the following cycle.
  - A transfer coincident with flush still counts in xfer_count.
  - Words already in fifo_async are not affected.
- xfer_count: +1 per transfer; holds at 2^CNT_WIDTH-1. Reset clears it; flush does not.
- Ordering: words leave in exactly the order rd_data was captured. No duplication and no loss, except on flush or reset.

Test Plan:
- Reset then stream: 5 words 0x11..0x15 in the FIFO, m_ready=1, RD_LATENCY=1 -> rd_en high 5 cycles. m_valid first rises 2 edges after the first rd_en. Output 0x11..0x15 on consecutive cycles; xfer_count=5.
- Backpressure: 8 words queued, m_ready=0 -> rd_en stops after occ+inflight=3 (BUF_DEPTH=3). m_data holds 0x11 stable. Release m_ready -> all 8 words arrive in order, with no rd_en while empty=1.
- Random m_ready (50%) with bursty empty, RD_LATENCY=2 -> scoreboard checks exact order. occ never exceeds 4, and rd_en&&empty is never true.
- Flush: with 2 buffered and 1 in flight, pulse flush -> m_valid=0 the next cycle. The in-flight word is dropped, and the next output is the next word from the FIFO.
- Saturation: CNT_WIDTH=4 with 20 transfers -> xfer_count stops at 15.
- Mid-stream reset: assert rd_rst_n=0 for 1 cycle with 2 in flight -> m_valid=0 and xfer_count=0 after the edge. Returning data is dropped, and there is no stray m_valid.
